// File: rtl/config_loader_pkg.sv
// Shared types, constants and helpers for the configuration chain loader.
package config_loader_pkg;

  // Stream word width; fixed by the fabric configuration protocol.
  localparam int unsigned WORD_W = 32;

  // Loader state encoding (3 bits).
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_SETUP = 3'd2;
  localparam state_t ST_PHI1  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;
  localparam state_t ST_PHI2  = 3'd5;
  localparam state_t ST_HOLD  = 3'd6;
  localparam state_t ST_DONE  = 3'd7;

  // Latch-enable encoding {phi1, phi2}.
  localparam logic [1:0] PHASE_NONE = 2'b00;
  localparam logic [1:0] PHASE_PHI1 = 2'b10;
  localparam logic [1:0] PHASE_PHI2 = 2'b01;

  // Phase outputs owned by each per-bit state.
  function automatic logic [1:0] phase_of(input state_t st);
    logic [1:0] ph;
    case (st)
      ST_PHI1: ph = PHASE_PHI1;
      ST_PHI2: ph = PHASE_PHI2;
      default: ph = PHASE_NONE;
    endcase
    return ph;
  endfunction

  // Bits to take from the next word: min(WORD_W, bits_left).
  function automatic logic [5:0] word_take(input logic [12:0] bits_left);
    logic [5:0] n;
    if (bits_left >= 13'(WORD_W)) begin
      n = 6'(WORD_W);
    end else begin
      n = bits_left[5:0];
    end
    return n;
  endfunction

endpackage

// File: rtl/config_phase_seq.sv
// Per-bit latch-enable sequencer: SETUP -> PHI1 -> GAP -> PHI2 -> HOLD.
// Phase enables are registered from the next state so they come straight off flops.
module config_phase_seq
  import config_loader_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit_start,
  output logic o_bit_done,
  output logic o_phi1,
  output logic o_phi2
);

  state_t     r_state;
  state_t     w_state_d;
  logic [1:0] r_phase;
  logic [1:0] w_phase_d;

  // Next bit state; ST_IDLE means no bit in flight.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  w_state_d = i_bit_start ? ST_SETUP : ST_IDLE;
      ST_SETUP: w_state_d = ST_PHI1;
      ST_PHI1:  w_state_d = ST_GAP;
      ST_GAP:   w_state_d = ST_PHI2;
      ST_PHI2:  w_state_d = ST_HOLD;
      ST_HOLD:  w_state_d = i_bit_start ? ST_SETUP : ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
    w_phase_d = phase_of(w_state_d);
  end

  // State and phase flops; reset drops both enables immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= PHASE_NONE;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
    end
  end

  assign o_bit_done = (r_state == ST_HOLD);
  assign o_phi1     = r_phase[1];
  assign o_phi2     = r_phase[0];

endmodule

// File: rtl/config_chain_loader.sv
// Streams configuration words MSB-first into a latch-based config chain,
// generating non-overlapping two-phase latch enables per bit.
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              conf_data,
  output logic              conf_phi1,
  output logic              conf_phi2,
  output logic              busy,
  output logic              done,
  output logic [12:0]       bits_left
);

  localparam logic [12:0] CHAIN_LEN_W = 13'(CHAIN_LEN);

  // Top-level state uses ST_IDLE, ST_FETCH, ST_DONE and ST_SETUP; the latter
  // stands for "bit in flight", whose SETUP..HOLD detail lives in the sequencer.
  state_t            r_state;
  state_t            w_state_d;
  // Bits below the one currently on conf_data; the current bit lives in r_conf_data.
  logic [WORD_W-2:0] r_shreg;
  logic [WORD_W-2:0] w_shreg_d;
  logic [5:0]        r_word_cnt;
  logic [5:0]        w_word_cnt_d;
  logic [12:0]       r_bits_left;
  logic [12:0]       w_bits_left_d;
  logic              r_conf_data;
  logic              w_conf_data_d;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_bit_start;
  logic              w_bit_done;
  logic              w_last_bit;
  logic              w_last_in_word;

  assign w_accept       = (r_state == ST_FETCH) && s_valid;
  assign w_last_bit     = (r_bits_left == 13'd1);
  assign w_last_in_word = (r_word_cnt == 6'd1);
  // Launch a bit on word capture, or back-to-back from HOLD while the word lasts.
  assign w_bit_start    = w_accept || (w_bit_done && !w_last_bit && !w_last_in_word);

  // Top-level next state, shift register and counters.
  always_comb begin
    w_state_d     = r_state;
    w_shreg_d     = r_shreg;
    w_word_cnt_d  = r_word_cnt;
    w_bits_left_d = r_bits_left;
    w_conf_data_d = r_conf_data;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_d     = ST_FETCH;
          w_bits_left_d = CHAIN_LEN_W;
        end
      end
      ST_FETCH: begin
        if (s_valid) begin
          w_state_d     = ST_SETUP;
          w_shreg_d     = s_data[WORD_W-2:0];
          w_conf_data_d = s_data[WORD_W-1];
          w_word_cnt_d  = word_take(r_bits_left);
        end
      end
      ST_SETUP: begin
        // Bit retires in HOLD; bits_left >= 1 here so it never underflows.
        if (w_bit_done) begin
          w_shreg_d     = {r_shreg[WORD_W-3:0], 1'b0};
          w_bits_left_d = r_bits_left - 13'd1;
          w_word_cnt_d  = r_word_cnt - 6'd1;
          if (w_last_bit) begin
            w_state_d = ST_DONE;
          end else if (w_last_in_word) begin
            w_state_d = ST_FETCH;
          end else begin
            w_conf_data_d = r_shreg[WORD_W-2];
          end
        end
      end
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_word_cnt  <= '0;
      r_bits_left <= '0;
      r_conf_data <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shreg     <= w_shreg_d;
      r_word_cnt  <= w_word_cnt_d;
      r_bits_left <= w_bits_left_d;
      r_conf_data <= w_conf_data_d;
      r_ready     <= (w_state_d == ST_FETCH);
      r_busy      <= (w_state_d == ST_FETCH) || (w_state_d == ST_SETUP);
      r_done      <= (w_state_d == ST_DONE);
    end
  end

  config_phase_seq u_phase_seq (
    .i_clk       (CLK),
    .i_rst_n     (resetn),
    .i_bit_start (w_bit_start),
    .o_bit_done  (w_bit_done),
    .o_phi1      (conf_phi1),
    .o_phi2      (conf_phi2)
  );

  assign s_ready   = r_ready;
  assign conf_data = r_conf_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bits_left = r_bits_left;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: three loader instances (CHAIN_LEN 8, 64, 40) on one clock.
module tb_config_chain_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  start;
  logic [31:0] s_data;
  logic        s_valid;
  logic [2:0]  s_ready, conf_data, phi1, phi2, busy, done;
  logic [12:0] bits_left [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_bad;

  int          p1_cnt [3], p2_cnt [3], ovl [3], adj [3];
  int          rdy_rise [3], done_cnt [3], nbits [3];
  logic [63:0] cap [3];
  logic        prev_p1 [3], prev_p2 [3], prev_rdy [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  config_chain_loader #(.CHAIN_LEN(8)) u_l8 (
    .CLK(clk), .resetn(resetn), .start(start[0]), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready[0]), .conf_data(conf_data[0]), .conf_phi1(phi1[0]),
    .conf_phi2(phi2[0]), .busy(busy[0]), .done(done[0]), .bits_left(bits_left[0])
  );
  config_chain_loader #(.CHAIN_LEN(64)) u_l64 (
    .CLK(clk), .resetn(resetn), .start(start[1]), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready[1]), .conf_data(conf_data[1]), .conf_phi1(phi1[1]),
    .conf_phi2(phi2[1]), .busy(busy[1]), .done(done[1]), .bits_left(bits_left[1])
  );
  config_chain_loader #(.CHAIN_LEN(40)) u_l40 (
    .CLK(clk), .resetn(resetn), .start(start[2]), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready[2]), .conf_data(conf_data[2]), .conf_phi1(phi1[2]),
    .conf_phi2(phi2[2]), .busy(busy[2]), .done(done[2]), .bits_left(bits_left[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int i);
    p1_cnt[i] = 0; p2_cnt[i] = 0; ovl[i] = 0; adj[i] = 0;
    rdy_rise[i] = 0; done_cnt[i] = 0; nbits[i] = 0; cap[i] = '0;
  endtask

  // Per-instance monitors sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (phi1[i] && phi2[i]) ovl[i]++;
      if ((phi1[i] && prev_p2[i]) || (phi2[i] && prev_p1[i])) adj[i]++;
      if (phi1[i]) begin
        p1_cnt[i]++;
        nbits[i]++;
        cap[i] = {cap[i][62:0], conf_data[i]};
      end
      if (phi2[i]) p2_cnt[i]++;
      if (s_ready[i] && !prev_rdy[i]) rdy_rise[i]++;
      if (done[i]) done_cnt[i]++;
      prev_p1[i]  = phi1[i];
      prev_p2[i]  = phi2[i];
      prev_rdy[i] = s_ready[i];
    end
  end

  // Start instance i, feed up to three words, optionally stall the second FETCH
  // and optionally poke start while busy. done_rel is measured from the start cycle.
  task automatic run_load(input int i, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int stall_n, input bit poke,
                          output int done_rel, output int taken);
    logic [31:0] words [3];
    int stalled, rel, s_cyc;
    words[0] = w0; words[1] = w1; words[2] = w2;
    taken = 0; stalled = 0; done_rel = -1; rel = 0; stall_bad = 0;
    clear_mon(i);
    @(negedge clk);
    start[i] = 1'b1;
    s_valid  = 1'b0;
    s_cyc    = cyc;
    while (done_rel < 0 && rel < 3000) begin
      @(negedge clk);
      rel      = cyc - s_cyc;
      start[i] = poke && (rel == 13);
      if (poke && rel == 14) begin
        check("busy_poke_bits_left", 64'(bits_left[i]), 64'd6);
        check("busy_poke_busy", 64'(busy[i]), 64'd1);
      end
      if (s_ready[i]) begin
        if (taken == 1 && stalled < stall_n) begin
          s_valid = 1'b0;
          stalled++;
          if (!busy[i] || phi1[i] || phi2[i]) stall_bad++;
        end else if (taken < 3) begin
          s_valid = 1'b1;
          s_data  = words[taken];
          taken++;
        end else begin
          s_valid = 1'b0;
        end
      end else begin
        s_valid = 1'b0;
      end
      if (done[i]) done_rel = rel;
    end
    s_valid  = 1'b0;
    start[i] = 1'b0;
    if (done_rel < 0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel, taken;
    resetn  = 1'b0;
    start   = '0;
    s_data  = '0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outputs_%0d", i),
            64'({s_ready[i], conf_data[i], phi1[i], phi2[i], busy[i], done[i], bits_left[i]}),
            64'd0);
    end

    // CHAIN_LEN=8, single word 0xA5000000, start poked while busy.
    run_load(0, 32'hA500_0000, 32'h0, 32'h0, 0, 1'b1, rel, taken);
    check("l8_bits", cap[0][7:0], 64'hA5);
    check("l8_nbits", 64'(nbits[0]), 64'd8);
    check("l8_done_cycle", 64'(rel), 64'd42);
    check("l8_done_once", 64'(done_cnt[0]), 64'd1);
    check("l8_words", 64'(taken), 64'd1);

    // CHAIN_LEN=64, two words, no stall.
    run_load(1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0, 0, 1'b0, rel, taken);
    check("l64_phi1_pulses", 64'(p1_cnt[1]), 64'd64);
    check("l64_phi2_pulses", 64'(p2_cnt[1]), 64'd64);
    check("l64_overlap", 64'(ovl[1]), 64'd0);
    check("l64_adjacent", 64'(adj[1]), 64'd0);
    check("l64_bits", cap[1], 64'hDEAD_BEEF_0123_4567);
    check("l64_done_cycle", 64'(rel), 64'd323);
    check("l64_done_once", 64'(done_cnt[1]), 64'd1);
    check("l64_idle_after", 64'({busy[1], s_ready[1]}), 64'd0);

    // CHAIN_LEN=40, partial second word; a third word is offered but never taken.
    run_load(2, 32'hFFFF_FFFF, 32'h5A00_0000, 32'h1234_5678, 0, 1'b0, rel, taken);
    check("l40_bits", 64'(cap[2][39:0]), 64'hFF_FFFF_FF5A);
    check("l40_nbits", 64'(nbits[2]), 64'd40);
    check("l40_ready_rises", 64'(rdy_rise[2]), 64'd2);
    check("l40_words", 64'(taken), 64'd2);
    check("l40_done_cycle", 64'(rel), 64'd203);
    check("l40_bits_left_end", 64'(bits_left[2]), 64'd0);

    // CHAIN_LEN=64 with the second word withheld for 20 cycles.
    run_load(1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0, 20, 1'b0, rel, taken);
    check("stall_done_cycle", 64'(rel), 64'd343);
    check("stall_phases_busy", 64'(stall_bad), 64'd0);
    check("stall_phi1_pulses", 64'(p1_cnt[1]), 64'd64);
    check("stall_bits", cap[1], 64'hDEAD_BEEF_0123_4567);

    // Asynchronous reset during a PHI1 cycle, then a clean reload.
    clear_mon(1);
    @(negedge clk);
    start[1] = 1'b1;
    s_valid  = 1'b1;
    s_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    start[1] = 1'b0;
    for (int k = 0; k < 20 && !phi1[1]; k++) @(negedge clk);
    check("rst_phi1_before", 64'(phi1[1]), 64'd1);
    #1 resetn = 1'b0;
    #1;
    check("rst_phi1_async", 64'(phi1[1]), 64'd0);
    check("rst_idle", 64'({busy[1], s_ready[1], done[1]}), 64'd0);
    check("rst_bits_left", 64'(bits_left[1]), 64'd0);
    @(negedge clk);
    resetn  = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    run_load(1, 32'hDEAD_BEEF, 32'h0123_4567, 32'h0, 0, 1'b0, rel, taken);
    check("reload_done_cycle", 64'(rel), 64'd323);
    check("reload_bits", cap[1], 64'hDEAD_BEEF_0123_4567);
    check("reload_done_once", 64'(done_cnt[1]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Serialises configuration words into a fabric tile's latch-based configuration chain, directly upstream of the chain's first LUT/MUX primitive. It accepts 32-bit words over a valid/ready stream and shifts them out MSB-first onto the chain's data input. For each bit it generates two non-overlapping latch enables: phi1 drives the first-stage latch, phi2 the second-stage latch. It reports busy/done to the tile configuration controller.

## Interface
Parameters:
- CHAIN_LEN, 64: total configuration bits in the chain; legal range 1..4096.
- WORD_W, 32: stream word width; fixed, not overridable.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  reset, asynchronous assert, active-low.
- start  input  1  single-cycle request to begin loading; sampled only in IDLE.
- s_data  input  32  configuration word; bit 31 is shifted first.
- s_valid  input  1  s_data holds a valid word.
- s_ready  output  1  loader accepts a word this cycle.
- conf_data  output  1  serial bit to the chain's CONFin.
- conf_phi1  output  1  first-stage latch enable (chain CLK pin).
- conf_phi2  output  1  second-stage latch enable (chain MODE pin).
- busy  output  1  high from the cycle after accepted start until DONE.
- done  output  1  one-cycle pulse when the last bit has been latched.
- bits_left  output  13  remaining bits, for debug and status.

## Operation
- States: IDLE, FETCH, SETUP, PHI1, GAP, PHI2, HOLD, DONE.
- IDLE: start=1 loads bits_left=CHAIN_LEN and moves to FETCH. Start in any other state is ignored.
- FETCH: s_ready=1. On s_valid, capture s_data into a 32-bit shift register and set word_cnt=min(32, bits_left). Next state SETUP.
- SETUP: conf_data=shreg[31]; both phases low.
- PHI1: conf_phi1=1.
- GAP: both phases low.
- PHI2: conf_phi2=1.
- HOLD: both phases low. Shift shreg left by 1, decrement bits_left and word_cnt.
  - Next state is DONE if bits_left reaches 0.
  - Otherwise FETCH if word_cnt reaches 0.
  - Otherwise SETUP.
- DONE: done=1 for one cycle, then IDLE.
- conf_data holds its value from SETUP through HOLD and only changes in SETUP.
- Partial last word: only the top bits_left bits are shifted out; the low bits are discarded.
- The first bit shifted ends up in the deepest chain position.
- conf_phi1 and conf_phi2 are never high in the same cycle, nor in adjacent cycles. All outputs are driven directly from flops.
- A stalled stream (s_valid=0 in FETCH) holds FETCH indefinitely with both phases low. Chain contents are unaffected.

## Timing
- Reset values: state IDLE, s_ready=0, conf_data=0, conf_phi1=0, conf_phi2=0, busy=0, done=0, bits_left=0.
- Reset mid-load returns to IDLE immediately and forces both phases low. A partial chain load is not resumed.
- start accepted at cycle 0 gives FETCH at cycle 1.
- Word handshake at cycle t gives SETUP at t+1, PHI1 at t+2, GAP at t+3, PHI2 at t+4, HOLD at t+5, next bit's SETUP at t+6.
- Each bit costs 5 cycles; each word adds at least 1 FETCH cycle.
- Minimum load time with s_valid held high: 1 + ceil(CHAIN_LEN/32) + 5·CHAIN_LEN cycles from start to done. For CHAIN_LEN=64 this is 323.
- Arithmetic: bits_left is 13 bits, unsigned, never below 0; word_cnt is 6 bits.

## Structure
- config_loader_pkg holds:
  - the state enum (3 bits);
  - WORD_W=32;
  - the phase output encoding per state (SETUP/GAP/HOLD=00, PHI1=10, PHI2=01).
- One sub-module, config_phase_seq: a 5-state per-bit sequencer from SETUP to HOLD, with a bit_start input and a bit_done output. The top level owns FETCH/IDLE/DONE, the shift register and the counters.

## Test plan
- CHAIN_LEN=8, start, word 0xA5000000 with s_valid held high:
  - conf_data sampled at each PHI1 reads 1,0,1,0,0,1,0,1;
  - done at cycle 2+40=42 after start.
- CHAIN_LEN=64, two words 0xDEADBEEF then 0x01234567, no stall:
  - 64 phi1 pulses and 64 phi2 pulses;
  - never both high, never adjacent;
  - done at cycle 323.
- CHAIN_LEN=40, words 0xFFFFFFFF and 0x5A000000:
  - only 8 bits of the second word are emitted (0,1,0,1,1,0,1,0);
  - s_ready never rises a third time.
- s_valid withheld for 20 cycles in the second FETCH:
  - phases stay low;
  - busy stays high;
  - done is delayed by exactly 20 cycles.
- resetn asserted during a PHI1 cycle:
  - conf_phi1 falls without waiting for a clock edge;
  - state is IDLE and bits_left=0;
  - a subsequent start loads cleanly.
- start pulsed while busy:
  - ignored, with no restart and no change to bits_left;
  - done pulses exactly once.
